// File: rtl/chunked_seq_adder_if.sv
// Handshake/operand bundle for chunked_seq_adder.
// The sub signal exists only when CHUNKED_SEQ_ADDER_SUB_EN is defined.
interface chunked_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef CHUNKED_SEQ_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional subtract mode (a + ~b + 1) enabled by CHUNKED_SEQ_ADDER_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk processed per edge, busy=1
// DONE  | done=1 for one cycle; start here re-launches back-to-back
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst_n,
    chunked_seq_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state;
    logic [NCHUNK-1:0][CHUNK-1:0] op_a;
    logic [NCHUNK-1:0][CHUNK-1:0] op_b;
    logic [NCHUNK-1:0][CHUNK-1:0] work;
    logic [NCHUNK-1:0][CHUNK-1:0] work_next;
    logic                         carry;
    logic [CW-1:0]                cnt;
    logic [CHUNK:0]               chunk_res;
    logic                         busy_q;
    logic                         done_q;
    logic [WIDTH-1:0]             sum_q;
    logic                         cout_q;
    logic [WIDTH-1:0]             b_eff;
    logic                         carry_init;

`ifdef CHUNKED_SEQ_ADDER_SUB_EN
    // Subtraction reuses the adder: invert b and force the initial carry.
    assign b_eff      = bus.sub ? ~bus.b : bus.b;
    assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff      = bus.b;
    assign carry_init = bus.cin;
`endif

    always_comb begin
        chunk_res      = {1'b0, op_a[cnt]} + {1'b0, op_b[cnt]} + {{CHUNK{1'b0}}, carry};
        work_next      = work;
        work_next[cnt] = chunk_res[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            work   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= b_eff;
                        carry  <= carry_init;
                        cnt    <= '0;
                        work   <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= chunk_res[CHUNK];
                    cnt   <= cnt + CW'(1);
                    // Outputs only update here, so partial chunks never leak out.
                    if (cnt == LAST) begin
                        sum_q  <= work_next;
                        cout_q <= chunk_res[CHUNK];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder: 8-bit/2-bit-chunk and 4-bit/1-bit-chunk instances.
module tb_chunked_seq_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chunked_seq_adder_if #(.WIDTH(8)) bus8 ();
    chunked_seq_adder_if #(.WIDTH(4)) bus4 ();

    chunked_seq_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    chunked_seq_adder #(.WIDTH(4), .CHUNK(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_sub8(input logic v);
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
        bus8.sub = v;
`else
        if (v) $display("note: sub requested without subtract support");
`endif
    endtask

    // Launches one operation, checks busy/hold during RUN and the done pulse width.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                        output logic [7:0] s, output logic co, output int lat);
        logic [7:0] prev_s;
        logic       prev_c;
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.cin = cin; set_sub8(sub); bus8.start = 1'b1;
        prev_s = bus8.sum;
        prev_c = bus8.cout;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a = 8'hAA; bus8.b = 8'hAA; bus8.cin = ~cin; set_sub8(sub);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus8.done) break;
            check("busy_in_run", {31'd0, bus8.busy}, 32'd1);
            check("out_hold_in_run", {23'd0, bus8.cout, bus8.sum}, {23'd0, prev_c, prev_s});
        end
        s  = bus8.sum;
        co = bus8.cout;
        check("busy_at_done", {31'd0, bus8.busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus8.done}, 32'd0);
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] s;
        logic       co;
        int         lat;
        int         cyc;
        int         done_cnt;
        int         second_at;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h3C, 8'h41, 1'b1, 1'b0, 8'h7E, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[6] = '{8'h97, 8'h6A, 1'b1, 1'b0, 8'h02, 1'b1};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; set_sub8(1'b0);
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
`ifdef CHUNKED_SEQ_ADDER_SUB_EN
        bus4.sub = 1'b0;
`endif

        // Reset then idle
        repeat (2) @(negedge clk);
        check("reset_out8", {21'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out8", {21'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, 32'd0);
            check("idle_out4", {25'd0, bus4.busy, bus4.done, bus4.cout, bus4.sum}, 32'd0);
        end

        // Directed vectors, inputs scrambled during RUN
        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, lat);
            check($sformatf("vec%0d_sum", i), {24'd0, s}, {24'd0, vecs[i].sum});
            check($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].cout});
            check($sformatf("vec%0d_latency", i), lat, 5);
        end

        // Back-to-back with start held high through RUN
        @(negedge clk);
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.a = 8'h11; bus8.b = 8'h22;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus8.done) break;
        end
        check("b2b_op1_latency", cyc, 5);
        check("b2b_op1_sum", {23'd0, bus8.cout, bus8.sum}, {23'd0, 1'b1, 8'h00});
        bus8.a = 8'h01; bus8.b = 8'h02;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        done_cnt  = 1;
        second_at = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus8.done) begin
                done_cnt++;
                if (second_at == 0) second_at = k;
            end
        end
        check("b2b_op2_spacing", second_at, 5);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_op2_sum", {23'd0, bus8.cout, bus8.sum}, {23'd0, 1'b0, 8'h03});

        // Reset in RUN before chunk 2
        @(negedge clk);
        bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out", {21'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, 32'd0);
        done_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus8.done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_busy_low", {31'd0, bus8.busy}, 32'd0);
        run8(8'h12, 8'h34, 1'b0, 1'b0, s, co, lat);
        check("post_rst_sum", {23'd0, co, s}, {23'd0, 1'b0, 8'h46});

`ifdef CHUNKED_SEQ_ADDER_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, s, co, lat);
        check("sub_5m7", {23'd0, co, s}, {23'd0, 1'b0, 8'hFE});
        run8(8'h07, 8'h05, 1'b0, 1'b1, s, co, lat);
        check("sub_7m5", {23'd0, co, s}, {23'd0, 1'b1, 8'h02});
        run8(8'h07, 8'h07, 1'b0, 1'b1, s, co, lat);
        check("sub_7m7", {23'd0, co, s}, {23'd0, 1'b1, 8'h00});
        check("sub_latency", lat, 5);
`endif

        // Exhaustive sweep of the 4-bit, 1-bit-chunk instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = c[0]; bus4.start = 1'b1;
                    @(posedge clk);
                    #1;
                    bus4.start = 1'b0;
                    cyc = 0;
                    while (cyc < 20) begin
                        @(negedge clk);
                        cyc++;
                        if (bus4.done) break;
                    end
                    check($sformatf("sweep_%0d_%0d_%0d", a, b, c),
                          {27'd0, bus4.cout, bus4.sum}, 32'(a + b + c));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
